// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 serializer.
// Accepts the core's UART write stream with real backpressure and drives the
// physical TX line. Each frame is start(0), 8 data bits LSB first, stop(1),
// and every bit is held CLKS_PER_BIT clocks.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] baud_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             tx_reg;

  logic push;
  logic pop;
  logic fifo_nonempty;
  logic baud_done;

  // Ready depends only on registered occupancy; a pop in a full cycle does
  // not open the door until the next cycle.
  assign wr_ready      = (count_reg != FULL_COUNT);
  assign push          = wr_valid && wr_ready;
  assign fifo_nonempty = (count_reg != '0);
  assign baud_done     = (baud_reg == BAUD_LAST);

  // The serializer takes a new byte when idle, or at the very end of a stop
  // bit so consecutive frames run with no idle gap.
  assign pop = fifo_nonempty &&
               ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && baud_done));

  assign tx         = tx_reg;
  assign fifo_count = count_reg;
  assign busy       = (state_reg != ST_IDLE) || fifo_nonempty;

  // FIFO storage write port; kept reset-free so it maps onto RAM.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Serializer FSM with baud counter; tx is always a registered output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= ST_IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          baud_reg <= '0;
          tx_reg   <= 1'b1;
          if (pop) begin
            shift_reg <= mem[rd_ptr_reg];
            state_reg <= ST_START;
            tx_reg    <= 1'b0;
          end
        end

        ST_START: begin
          if (baud_done) begin
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            state_reg   <= ST_DATA;
            tx_reg      <= shift_reg[0];
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

        ST_DATA: begin
          if (baud_done) begin
            baud_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= ST_STOP;
              tx_reg    <= 1'b1;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              shift_reg   <= shift_reg >> 1;
              tx_reg      <= shift_reg[1];
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

        ST_STOP: begin
          if (baud_done) begin
            baud_reg <= '0;
            if (pop) begin
              shift_reg <= mem[rd_ptr_reg];
              state_reg <= ST_START;
              tx_reg    <= 1'b0;
            end else begin
              state_reg <= ST_IDLE;
              tx_reg    <= 1'b1;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          baud_reg  <= '0;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=16.
// A line monitor decodes 8N1 frames from tx into rx_q; scenario tasks drive
// the write port and compare against hand-derived expectations.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  logic       CLK;
  logic       RST;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_q[$];
  int         frame_err = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Line monitor: detects a start bit and samples each bit mid-period.
  initial begin
    bit         active;
    int         cnt;
    logic [7:0] b;
    active = 1'b0;
    cnt    = 0;
    b      = 8'h00;
    forever begin
      @(negedge CLK);
      if (RST === 1'b1) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1'b1;
          cnt    = 0;
        end
      end else begin
        cnt++;
        if (cnt == 2 && tx !== 1'b0) frame_err++;
        if (cnt >= 6 && cnt <= 34 && (cnt % 4) == 2) b[(cnt - 6) / 4] = tx;
        if (cnt == 38) begin
          if (tx !== 1'b1) frame_err++;
          rx_q.push_back(b);
          active = 1'b0;
        end
      end
    end
  end

  // Global time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for the block to go idle; ok reports whether it did.
  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge CLK); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; wr_valid = 1'b0; wr_data = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", wr_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    RST = 1'b0;
    @(posedge CLK); #1;
    $display("test_reset: done, errors=%0d", errors);
  endtask

  task automatic test_single_byte();
    bit exp[10] = '{0,1,0,1,0,1,0,1,0,1};
    bit ok;
    rx_q.delete(); frame_err = 0;
    wr_valid = 1'b1; wr_data = 8'h55;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", wr_ready); end
    @(posedge CLK); #1;          // acceptance edge
    wr_valid = 1'b0; wr_data = 8'hXX;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_accept: got %b want 1", tx); end
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL single_count_accept: got %0d want 1", fifo_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_accept: got %b want 1", busy); end
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;        // start edge + i
      checks++; if (tx !== exp[i / 4]) begin errors++; $display("FAIL single_tx cycle %0d: got %b want %b", i, tx, exp[i / 4]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy cycle %0d: got %b want 1", i, busy); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL single_ready cycle %0d: got %b want 1", i, wr_ready); end
    end
    @(posedge CLK); #1;          // start edge + 40
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_end: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_idle: timeout waiting for idle"); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin errors++; $display("FAIL single_rx: got %0d bytes first %h want 1 byte 55", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hXX); end
    checks++; if (frame_err != 0) begin errors++; $display("FAIL single_framing: got %0d errors want 0", frame_err); end
    $display("test_single_byte: done, errors=%0d", errors);
  endtask

  task automatic test_back_to_back();
    bit exp[20] = '{0,1,1,0,0,0,1,0,1,1, 0,1,1,1,1,0,0,0,0,1};
    bit ok;
    rx_q.delete(); frame_err = 0;
    wr_valid = 1'b1; wr_data = 8'hA3;
    @(posedge CLK); #1;          // A3 accepted
    wr_data = 8'h0F;
    @(posedge CLK); #1;          // 0F accepted, A3 popped: start edge
    wr_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (i > 0) begin
        @(posedge CLK); #1;
      end
      checks++; if (tx !== exp[i / 4]) begin errors++; $display("FAIL b2b_tx cycle %0d: got %b want %b", i, tx, exp[i / 4]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy cycle %0d: got %b want 1", i, busy); end
    end
    @(posedge CLK); #1;          // start edge + 80
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL b2b_tx_end: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_idle: timeout waiting for idle"); end
    checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL b2b_rx_count: got %0d want 2", rx_q.size()); end
    else begin
      checks++; if (rx_q[0] !== 8'hA3) begin errors++; $display("FAIL b2b_rx0: got %h want a3", rx_q[0]); end
      checks++; if (rx_q[1] !== 8'h0F) begin errors++; $display("FAIL b2b_rx1: got %h want 0f", rx_q[1]); end
    end
    $display("test_back_to_back: done, errors=%0d", errors);
  endtask

  task automatic test_full_fifo();
    int         accepted = 0;
    logic [7:0] nxt = 8'h00;
    int         pulses[$];
    int         consec = 0;
    bit         prev = 1'b0;
    bit         rd;
    bit         ok;
    rx_q.delete(); frame_err = 0;
    for (int g = 0; g < 100; g++) begin
      wr_valid = 1'b1; wr_data = nxt;
      if (!wr_ready) break;
      @(posedge CLK); #1;
      accepted++; nxt++;
    end
    checks++; if (accepted != 17) begin errors++; $display("FAIL full_accepted: got %0d want 17", accepted); end
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d want 16", fifo_count); end
    for (int t = 0; t < 130; t++) begin
      rd = wr_ready;
      if (rd) pulses.push_back(t);
      if (rd && prev) consec++;
      prev = rd;
      wr_data = nxt;
      @(posedge CLK); #1;
      if (rd) begin
        accepted++; nxt++;
      end
    end
    wr_valid = 1'b0;
    checks++; if (consec != 0) begin errors++; $display("FAIL full_pulse_width: got %0d multi-cycle ready pulses want 0", consec); end
    checks++; if (pulses.size() != 3) begin errors++; $display("FAIL full_pulse_count: got %0d want 3", pulses.size()); end
    else begin
      checks++; if (pulses[1] - pulses[0] != 40) begin errors++; $display("FAIL full_pulse_gap1: got %0d want 40", pulses[1] - pulses[0]); end
      checks++; if (pulses[2] - pulses[1] != 40) begin errors++; $display("FAIL full_pulse_gap2: got %0d want 40", pulses[2] - pulses[1]); end
    end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_idle: timeout waiting for drain"); end
    checks++; if (rx_q.size() != accepted) begin errors++; $display("FAIL full_rx_count: got %0d want %0d", rx_q.size(), accepted); end
    for (int i = 0; i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== 8'(i)) begin errors++; $display("FAIL full_rx byte %0d: got %h want %h", i, rx_q[i], 8'(i)); end
    end
    checks++; if (frame_err != 0) begin errors++; $display("FAIL full_framing: got %0d errors want 0", frame_err); end
    $display("test_full_fifo: done, %0d bytes, errors=%0d", accepted, errors);
  endtask

  task automatic test_pointer_wrap();
    int n = 0;
    int maxc = 0;
    bit acc;
    bit ok;
    rx_q.delete(); frame_err = 0;
    for (int g = 0; g < 4000 && n < 40; g++) begin
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      wr_valid = 1'b1; wr_data = 8'(n * 29 + 3);
      acc = wr_ready;
      @(posedge CLK); #1;
      if (acc) n++;
    end
    wr_valid = 1'b0;
    checks++; if (n != 40) begin errors++; $display("FAIL wrap_pushed: got %0d want 40", n); end
    checks++; if (maxc > 16) begin errors++; $display("FAIL wrap_max_count: got %0d want <=16", maxc); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_idle: timeout waiting for drain"); end
    checks++; if (rx_q.size() != 40) begin errors++; $display("FAIL wrap_rx_count: got %0d want 40", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 40; i++) begin
      checks++; if (rx_q[i] !== 8'(i * 29 + 3)) begin errors++; $display("FAIL wrap_rx byte %0d: got %h want %h", i, rx_q[i], 8'(i * 29 + 3)); end
    end
    checks++; if (frame_err != 0) begin errors++; $display("FAIL wrap_framing: got %0d errors want 0", frame_err); end
    $display("test_pointer_wrap: done, max count %0d, errors=%0d", maxc, errors);
  endtask

  task automatic test_reset_mid_frame();
    int tx_bad = 0;
    bit ok;
    rx_q.delete(); frame_err = 0;
    // First byte F7 has data bit 3 = 0, so the line is low just before reset.
    wr_valid = 1'b1; wr_data = 8'hF7;
    for (int j = 0; j < 6; j++) begin
      @(posedge CLK); #1;        // edge Pj; start edge is P1
      wr_data = 8'(8'h30 + j);
    end
    wr_valid = 1'b0;
    checks++; if (fifo_count !== 5'd5) begin errors++; $display("FAIL rstmid_queued: got %0d want 5", fifo_count); end
    repeat (13) @(posedge CLK);  // now at start edge + 17, inside data bit 3
    #1;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rstmid_bit3: got %b want 0", tx); end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", tx); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", fifo_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", wr_ready); end
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK); #1;
      if (tx !== 1'b1 || busy !== 1'b0) tx_bad++;
    end
    checks++; if (tx_bad != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", tx_bad); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL rstmid_no_frames: got %0d frames want 0", rx_q.size()); end
    wr_valid = 1'b1; wr_data = 8'h7E;
    @(posedge CLK); #1;
    wr_valid = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_idle: timeout waiting for idle"); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h7E) begin errors++; $display("FAIL rstmid_rx: got %0d bytes first %h want 1 byte 7e", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hXX); end
    checks++; if (frame_err != 0) begin errors++; $display("FAIL rstmid_framing: got %0d errors want 0", frame_err); end
    $display("test_reset_mid_frame: done, errors=%0d", errors);
  endtask

  task automatic test_valid_without_ready();
    int accepted = 0;
    int junk = 0;
    bit ok;
    rx_q.delete(); frame_err = 0;
    for (int g = 0; g < 100; g++) begin
      wr_valid = 1'b1; wr_data = 8'(8'hC0 + accepted);
      if (!wr_ready) break;
      @(posedge CLK); #1;
      accepted++;
    end
    for (int k = 0; k < 100; k++) begin
      if (wr_ready) break;
      wr_valid = 1'b1;
      wr_data  = (k % 2 == 0) ? 8'hEE : 8'h11;
      junk++;
      @(posedge CLK); #1;
    end
    wr_valid = 1'b0;
    checks++; if (accepted != 17) begin errors++; $display("FAIL novr_accepted: got %0d want 17", accepted); end
    checks++; if (junk < 10) begin errors++; $display("FAIL novr_junk_cycles: got %0d want >=10", junk); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL novr_idle: timeout waiting for drain"); end
    checks++; if (rx_q.size() != 17) begin errors++; $display("FAIL novr_rx_count: got %0d want 17", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 17; i++) begin
      checks++; if (rx_q[i] !== 8'(8'hC0 + i)) begin errors++; $display("FAIL novr_rx byte %0d: got %h want %h", i, rx_q[i], 8'(8'hC0 + i)); end
    end
    checks++; if (frame_err != 0) begin errors++; $display("FAIL novr_framing: got %0d errors want 0", frame_err); end
    $display("test_valid_without_ready: done, errors=%0d", errors);
  endtask

  initial begin
    RST = 1'b1; wr_valid = 1'b0; wr_data = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_fifo();
    test_pointer_wrap();
    test_reset_mid_frame();
    test_valid_without_ready();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
